// File: rtl/traffic_pkg.sv
// Shared traffic-light controller definitions: phase timer state type and
// default timer dimensions also used by the controller FSM.
package traffic_pkg;

  localparam int unsigned TIMER_WIDTH_DEF    = 4;
  localparam int unsigned TIMER_EXT_STEP_DEF = 3;

  // Legacy state encodings, kept so older code comparing raw codes still matches.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    HOLD = ST_HOLD
  } timer_state_t;

endpackage

// File: rtl/phase_timer_sat_add.sv
// Saturating count adjuster: a + (add ? STEP : 0) - dec, clamped to [0, 2^WIDTH-1].
module sat_add #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEP  = 3
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_add,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_sum
);

  logic [WIDTH:0] w_step;
  logic [WIDTH:0] w_raw;

  // One extra bit of headroom; the top bit flags overflow past the count range.
  always_comb begin
    w_step = i_add ? (WIDTH+1)'(STEP) : '0;
    w_raw  = {1'b0, i_a} + w_step - {{WIDTH{1'b0}}, i_dec};
    if (i_dec && (w_step == '0) && (i_a == '0))
      o_sum = '0;
    else if (w_raw[WIDTH])
      o_sum = '1;
    else
      o_sum = w_raw[WIDTH-1:0];
  end

endmodule

// File: rtl/phase_timer.sv
// Phase timer: counts one-second ticks down from a loaded duration, with
// pause/hold, periodic auto-reload and saturating extension.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned WIDTH    = TIMER_WIDTH_DEF,
  parameter int unsigned EXT_STEP = TIMER_EXT_STEP_DEF
) (
  input  logic             clk,
  input  logic             Reset_Sync,
  input  logic             oneHz_enable,
  input  logic             start_timer,
  input  logic [WIDTH-1:0] Value,
  input  logic             periodic,
  input  logic             pause,
  input  logic             extend,
  output logic             expired,
  output logic             busy,
  output logic [WIDTH-1:0] remaining
);

  timer_state_t     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_reload, w_reload_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_expired, w_expired_nxt;
  logic             r_busy;

  logic             w_add;
  logic             w_dec;
  logic [WIDTH-1:0] w_sum;

  // A tick only counts in RUN when no pause transition is happening this cycle.
  assign w_add = extend && ((r_state == RUN) || (r_state == HOLD));
  assign w_dec = oneHz_enable && !pause && (r_state == RUN);

  sat_add #(
    .WIDTH (WIDTH),
    .STEP  (EXT_STEP)
  ) u_sat_add (
    .i_a   (r_count),
    .i_add (w_add),
    .i_dec (w_dec),
    .o_sum (w_sum)
  );

  // Next-state decode; start overrides everything except reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_reload_nxt  = r_reload;
    w_mode_nxt    = r_mode;
    w_expired_nxt = 1'b0;
    if (start_timer) begin
      w_count_nxt  = Value;
      w_reload_nxt = Value;
      w_mode_nxt   = periodic;
      if (Value == '0) begin
        w_state_nxt   = IDLE;
        w_expired_nxt = 1'b1;
      end else begin
        w_state_nxt = RUN;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (pause) begin
            w_state_nxt = HOLD;
            if (extend) w_count_nxt = w_sum;
          end else if (oneHz_enable && !extend && (r_count == WIDTH'(1))) begin
            w_expired_nxt = 1'b1;
            if (r_mode) begin
              w_count_nxt = r_reload;
            end else begin
              w_count_nxt = '0;
              w_state_nxt = IDLE;
            end
          end else if (extend || oneHz_enable) begin
            w_count_nxt = w_sum;
          end
        end
        HOLD: begin
          if (extend) w_count_nxt = w_sum;
          if (!pause) w_state_nxt = RUN;
        end
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_mode    <= 1'b0;
      r_expired <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_reload  <= w_reload_nxt;
      r_mode    <= w_mode_nxt;
      r_expired <= w_expired_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign expired   = r_expired;
  assign busy      = r_busy;
  assign remaining = r_count;

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer: behavioural model compared every cycle
// plus hand-computed literal expectations for the directed scenarios.
module tb_phase_timer;

  localparam int W    = 4;
  localparam int EXT  = 3;
  localparam int MAXV = 15;

  logic         clk = 1'b0;
  logic         rst, tk, st, per, pa, ex;
  logic [W-1:0] val;
  logic         expd, bsy;
  logic [W-1:0] rem;

  always #5 clk = ~clk;

  phase_timer #(
    .WIDTH    (W),
    .EXT_STEP (EXT)
  ) dut (
    .clk          (clk),
    .Reset_Sync   (rst),
    .oneHz_enable (tk),
    .start_timer  (st),
    .Value        (val),
    .periodic     (per),
    .pause        (pa),
    .extend       (ex),
    .expired      (expd),
    .busy         (bsy),
    .remaining    (rem)
  );

  int vectors     = 0;
  int miscompares = 0;
  int exp_seen    = 0;
  bit cmp_en      = 0;

  // Model state: whether counting/paused, the count, reload value, mode.
  bit m_run = 0, m_hold = 0, m_mode = 0, m_exp = 0;
  int m_cnt = 0, m_rel = 0;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Behavioural model, evaluated at each rising edge from the sampled inputs.
  always @(posedge clk) begin
    bit e_n, do_tick;
    int c;
    e_n = 0;
    if (rst) begin
      m_run = 0; m_hold = 0; m_cnt = 0; m_rel = 0; m_mode = 0;
    end else if (st) begin
      m_cnt = int'(val); m_rel = int'(val); m_mode = per;
      if (val == 0) begin
        m_run = 0; m_hold = 0; e_n = 1;
      end else begin
        m_run = 1; m_hold = 0;
      end
    end else if (m_run || m_hold) begin
      c = m_cnt;
      do_tick = m_run && !pa && tk;
      if (m_run && pa) begin
        m_run = 0; m_hold = 1;
      end else if (m_hold && !pa) begin
        m_run = 1; m_hold = 0;
      end
      if (ex) begin
        c = c - int'(do_tick) + EXT;
        if (c > MAXV) c = MAXV;
      end else if (do_tick) begin
        if (c == 1) begin
          e_n = 1;
          if (m_mode) c = m_rel;
          else begin c = 0; m_run = 0; end
        end else begin
          c = c - 1;
        end
      end
      m_cnt = c;
    end
    m_exp = e_n;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("expired", int'(expd), int'(m_exp));
      chk("busy", int'(bsy), int'(m_run || m_hold));
      chk("remaining", int'(rem), m_cnt);
      if (expd === 1'b1) exp_seen++;
    end
  end

  task automatic step(input bit r, input bit s, input int v, input bit p,
                      input bit pz, input bit e, input bit t);
    rst = r; st = s; val = v[W-1:0]; per = p; pa = pz; ex = e; tk = t;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick2(input bit pz);
    step(0, 0, 0, 0, pz, 0, 1);
    step(0, 0, 0, 0, pz, 0, 0);
  endtask

  int e0;

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    cmp_en = 1;
    chk("reset_remaining", int'(rem), 0);
    chk("reset_busy", int'(bsy), 0);
    chk("reset_expired", int'(expd), 0);

    // One-shot, Value=6, tick every other cycle.
    e0 = exp_seen;
    step(0, 1, 6, 0, 0, 0, 1);
    chk("t1_start_rem", int'(rem), 6);
    chk("t1_start_busy", int'(bsy), 1);
    for (int i = 0; i < 6; i++) tick2(0);
    chk("t1_end_rem", int'(rem), 0);
    chk("t1_end_busy", int'(bsy), 0);
    chk("t1_expiries", exp_seen - e0, 1);

    // Periodic, Value=3, 8 ticks.
    step(1, 0, 0, 0, 0, 0, 0);
    e0 = exp_seen;
    step(0, 1, 3, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick2(0);
    chk("t2_rem", int'(rem), 1);
    chk("t2_busy", int'(bsy), 1);
    chk("t2_expiries", exp_seen - e0, 2);

    // Pause for 4 ticks mid-count.
    step(1, 0, 0, 0, 0, 0, 0);
    e0 = exp_seen;
    step(0, 1, 5, 0, 0, 0, 0);
    tick2(0); tick2(0);
    step(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 1);
    chk("t3_hold_rem", int'(rem), 3);
    chk("t3_hold_busy", int'(bsy), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t3_resume_rem", int'(rem), 3);
    for (int i = 0; i < 3; i++) tick2(0);
    chk("t3_expiries", exp_seen - e0, 1);
    chk("t3_busy", int'(bsy), 0);

    // Saturating extend, extend+tick at 1, extend while held.
    step(1, 0, 0, 0, 0, 0, 0);
    e0 = exp_seen;
    step(0, 1, 14, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t4_sat", int'(rem), 15);
    for (int i = 0; i < 14; i++) tick2(0);
    chk("t4_at1", int'(rem), 1);
    step(0, 0, 0, 0, 0, 1, 1);
    idle_step();
    chk("t4_ext_tick", int'(rem), 3);
    chk("t4_no_exp", exp_seen - e0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("t4_ext_pause", int'(rem), 6);
    step(0, 0, 0, 0, 1, 1, 1);
    chk("t4_ext_hold", int'(rem), 9);

    // Zero-duration start, then idle ignores extend/pause/tick.
    step(1, 0, 0, 0, 0, 0, 0);
    e0 = exp_seen;
    step(0, 1, 0, 1, 0, 0, 1);
    chk("t5_exp", int'(expd), 1);
    chk("t5_busy", int'(bsy), 0);
    idle_step();
    chk("t5_exp_gone", int'(expd), 0);
    step(0, 0, 0, 0, 1, 1, 1);
    chk("t5_idle_rem", int'(rem), 0);
    chk("t5_idle_busy", int'(bsy), 0);
    chk("t5_expiries", exp_seen - e0, 1);

    // Reset mid-count, restart mid-count, reset on expiry tick.
    e0 = exp_seen;
    step(0, 1, 6, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick2(0);
    chk("t6_at2", int'(rem), 2);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("t6_rst_rem", int'(rem), 0);
    chk("t6_rst_busy", int'(bsy), 0);
    step(0, 1, 6, 0, 0, 0, 0);
    tick2(0); tick2(0);
    chk("t6_at4", int'(rem), 4);
    step(0, 1, 2, 0, 0, 0, 1);
    chk("t6_restart", int'(rem), 2);
    tick2(0);
    step(1, 0, 0, 0, 0, 0, 1);
    idle_step();
    chk("t6_no_exp", exp_seen - e0, 0);

    idle_step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
